// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port main RAM between instruction fetch and
// load/store. Round-robin arbitration, WAIT_CYCLES extra access cycles, one
// access in flight at a time, and a one-cycle response pulse per accepted
// request. This block is the only driver of the RAM control/address/data pins.
module ram_arbiter #(
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [DATA_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,
    input  logic              d_req_valid,
    input  logic              d_req_write,
    input  logic [DATA_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              d_resp_err,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    output logic [DATA_W-1:0] ram_mem_addr,
    output logic [DATA_W-1:0] ram_mem_data,
    input  logic [DATA_W-1:0] ram_mem_output_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state_r;
    logic                own_data_r;   // 1: data port owns the access, 0: fetch
    logic                last_data_r;  // 1: most recent grant went to data
    logic                wr_r;
    logic [DATA_W-1:2]   addr_r;       // word address; byte offset never reaches RAM
    logic [DATA_W-1:0]   wdata_r;
    logic [3:0]          cnt_r;

    logic                grant_if_s;
    logic                grant_d_s;
    logic                lsb_unused_s;

    // Fetch byte offset is ignored; fold it into a sink so it is visibly unused.
    assign lsb_unused_s = ^if_req_addr[1:0];

    // Round-robin winner selection, only while idle and out of reset.
    always_comb begin
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        if (reset && (state_r == ST_IDLE)) begin
            if (if_req_valid && (!d_req_valid || last_data_r)) begin
                grant_if_s = 1'b1;
            end else if (d_req_valid) begin
                grant_d_s = 1'b1;
            end else begin
                grant_if_s = 1'b0;
                grant_d_s  = 1'b0;
            end
        end else begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end
    end

    assign if_req_ready = grant_if_s;
    assign d_req_ready  = grant_d_s;

    // RAM pins decoded from registered state only; all zero outside ACCESS,
    // so an asynchronous reset removes any write strobe immediately.
    always_comb begin
        ram_write_enable = 1'b0;
        ram_read_enable  = 1'b0;
        ram_mem_addr     = '0;
        ram_mem_data     = '0;
        if (state_r == ST_ACCESS) begin
            ram_mem_addr = {addr_r, 2'b00};
            if (wr_r) begin
                ram_mem_data     = wdata_r;
                ram_write_enable = (cnt_r == 4'd0);
            end else begin
                ram_read_enable = 1'b1;
            end
        end else begin
            ram_mem_addr = '0;
        end
    end

    // Access FSM: latch request, count wait states, capture and pulse response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            own_data_r    <= 1'b0;
            last_data_r   <= 1'b1;
            wr_r          <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            cnt_r         <= 4'd0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            d_resp_valid  <= 1'b0;
            d_resp_data   <= '0;
            d_resp_err    <= 1'b0;
        end else begin
            if_resp_valid <= 1'b0;
            d_resp_valid  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_if_s) begin
                        own_data_r  <= 1'b0;
                        last_data_r <= 1'b0;
                        wr_r        <= 1'b0;
                        addr_r      <= if_req_addr[DATA_W-1:2];
                        wdata_r     <= '0;
                        cnt_r       <= WAIT_INIT;
                        state_r     <= ST_ACCESS;
                    end else if (grant_d_s) begin
                        own_data_r  <= 1'b1;
                        last_data_r <= 1'b1;
                        wr_r        <= d_req_write;
                        addr_r      <= d_req_addr[DATA_W-1:2];
                        wdata_r     <= d_req_wdata;
                        cnt_r       <= WAIT_INIT;
                        if (d_req_addr[1:0] != 2'b00) begin
                            // Misaligned: answer with an error, never touch RAM.
                            d_resp_valid <= 1'b1;
                            d_resp_data  <= '0;
                            d_resp_err   <= 1'b1;
                            state_r      <= ST_RESP;
                        end else begin
                            state_r <= ST_ACCESS;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                        if (own_data_r) begin
                            d_resp_valid <= 1'b1;
                            d_resp_err   <= 1'b0;
                            d_resp_data  <= wr_r ? '0 : ram_mem_output_data;
                        end else begin
                            if_resp_valid <= 1'b1;
                            if_resp_data  <= ram_mem_output_data;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model (one outstanding access, due-cycle
// arithmetic, round-robin by last grant, word memory array).
module tb_ram_arbiter;
    localparam int W = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [31:0] if_req_addr, if_resp_data;
    logic        d_req_valid, d_req_write, d_req_ready, d_resp_valid, d_resp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
    logic        ram_write_enable, ram_read_enable;
    logic [31:0] ram_mem_addr, ram_mem_data, ram_mem_output_data;

    // Second instance with zero wait states.
    logic        z_if_valid, z_if_ready, z_if_resp_valid;
    logic [31:0] z_if_addr, z_if_resp_data;
    logic        z_d_ready, z_d_resp_valid, z_d_resp_err;
    logic [31:0] z_d_resp_data;
    logic        z_we, z_re;
    logic [31:0] z_addr, z_data, z_rdata;

    logic [31:0] ram  [0:63];
    logic [31:0] ramz [0:63];
    logic [31:0] mref [0:63];

    ram_arbiter #(.DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
        .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
        .ram_mem_addr(ram_mem_addr), .ram_mem_data(ram_mem_data),
        .ram_mem_output_data(ram_mem_output_data)
    );

    ram_arbiter #(.DATA_W(32), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset),
        .if_req_valid(z_if_valid), .if_req_addr(z_if_addr), .if_req_ready(z_if_ready),
        .if_resp_valid(z_if_resp_valid), .if_resp_data(z_if_resp_data),
        .d_req_valid(1'b0), .d_req_write(1'b0), .d_req_addr(32'h0),
        .d_req_wdata(32'h0), .d_req_ready(z_d_ready),
        .d_resp_valid(z_d_resp_valid), .d_resp_data(z_d_resp_data), .d_resp_err(z_d_resp_err),
        .ram_write_enable(z_we), .ram_read_enable(z_re),
        .ram_mem_addr(z_addr), .ram_mem_data(z_data),
        .ram_mem_output_data(z_rdata)
    );

    // Behavioural RAMs: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (ram_write_enable) ram[ram_mem_addr[7:2]] <= ram_mem_data;
        if (z_we) ramz[z_addr[7:2]] <= z_data;
    end
    assign ram_mem_output_data = ram[ram_mem_addr[7:2]];
    assign z_rdata             = ramz[z_addr[7:2]];

    int errors = 0;
    int checks = 0;

    // Reference model state: at most one accepted, unfinished transaction.
    int          cyc;
    bit          p_v, p_fetch, p_wr, p_err;
    logic [31:0] p_addr, p_wdata;
    int          p_hs, p_due;
    bit          last_data;
    int          glog[$];
    int          we_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " if_ready"}, if_req_ready, 0);
        chk({tag, " d_ready"}, d_req_ready, 0);
        chk({tag, " if_resp"}, {if_resp_valid, d_resp_valid, d_resp_err}, 0);
        chk({tag, " resp_data"}, if_resp_data | d_resp_data, 0);
        chk({tag, " ram_en"}, {ram_write_enable, ram_read_enable}, 0);
        chk({tag, " ram_addr"}, ram_mem_addr, 0);
        chk({tag, " ram_data"}, ram_mem_data, 0);
    endtask

    // One clock cycle: check DUT against the model, advance the model,
    // drop any request that was just accepted.
    task automatic tick();
        bit          acc, idle, last_acc, exp_ifr, exp_dr;
        logic [31:0] rd;
        #1;
        idle     = !p_v;
        acc      = p_v && !p_err && (cyc > p_hs) && (cyc <= p_hs + W + 1);
        last_acc = acc && (cyc == p_hs + W + 1);
        chk("ram_read_enable", ram_read_enable, acc && !p_wr);
        chk("ram_write_enable", ram_write_enable, last_acc && p_wr);
        chk("ram_mem_addr", ram_mem_addr, acc ? {p_addr[31:2], 2'b00} : 32'h0);
        chk("ram_mem_data", ram_mem_data, (acc && p_wr) ? p_wdata : 32'h0);
        chk("if_resp_valid", if_resp_valid, p_v && (cyc == p_due) && p_fetch);
        chk("d_resp_valid", d_resp_valid, p_v && (cyc == p_due) && !p_fetch);
        if (ram_write_enable) we_cnt++;
        if (p_v && (cyc == p_due)) begin
            rd = (p_err || p_wr) ? 32'h0 : mref[p_addr[7:2]];
            if (p_fetch) begin
                chk("if_resp_data", if_resp_data, rd);
            end else begin
                chk("d_resp_data", d_resp_data, rd);
                chk("d_resp_err", d_resp_err, p_err);
            end
            p_v = 1'b0;
        end
        if (last_acc && p_wr) mref[p_addr[7:2]] = p_wdata;
        exp_ifr = idle && if_req_valid && (!d_req_valid || last_data);
        exp_dr  = idle && d_req_valid && !exp_ifr;
        chk("if_req_ready", if_req_ready, exp_ifr);
        chk("d_req_ready", d_req_ready, exp_dr);
        if (if_req_valid && if_req_ready) glog.push_back(0);
        else if (d_req_valid && d_req_ready) glog.push_back(1);
        if (exp_ifr || exp_dr) begin
            p_v = 1'b1; p_fetch = exp_ifr; p_hs = cyc; last_data = exp_dr;
            if (exp_ifr) begin
                p_addr = if_req_addr; p_wr = 1'b0; p_err = 1'b0; p_wdata = 32'h0;
            end else begin
                p_addr = d_req_addr; p_wr = d_req_write; p_wdata = d_req_wdata;
                p_err  = (d_req_addr[1:0] != 2'b00);
            end
            p_due = p_err ? cyc + 1 : cyc + W + 2;
        end
        @(negedge clk);
        cyc++;
        if (exp_ifr) if_req_valid = 1'b0;
        if (exp_dr)  d_req_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        if_req_valid = 1'b0; if_req_addr = 32'h0;
        d_req_valid = 1'b0; d_req_write = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0;
        z_if_valid = 1'b0; z_if_addr = 32'h0;
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom; mref[i] = ram[i]; ramz[i] = $urandom;
        end
        ram[4] = 32'hDEADBEEF; mref[4] = 32'hDEADBEEF;
        p_v = 1'b0; last_data = 1'b1; cyc = 0; we_cnt = 0;
        if_req_valid = 1'b1;                       // ready must stay 0 in reset
        #2;
        chk_all_zero("reset");
        if_req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Fetch of 0x10 with one wait state.
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        tick(); tick(); tick();
        #1;
        chk("fetch resp cycle3 valid", if_resp_valid, 1);
        chk("fetch resp cycle3 data", if_resp_data, 32'hDEADBEEF);
        tick(); tick();

        // Store then load of 0x20: exactly one write edge.
        we_cnt = 0;
        d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 32'h20; d_req_wdata = 32'h12345678;
        repeat (5) tick();
        chk("store write pulses", we_cnt, 1);
        d_req_valid = 1'b1; d_req_write = 1'b0;
        repeat (5) tick();
        chk("load data held", d_resp_data, 32'h12345678);

        // Both valid: strict alternation starting with fetch.
        glog.delete();
        for (int n = 0; n < 40 && glog.size() < 4; n++) begin
            if_req_valid = 1'b1; if_req_addr = 32'($urandom_range(0, 63)) << 2;
            d_req_valid  = 1'b1; d_req_write = 1'b0; d_req_addr = 32'($urandom_range(0, 63)) << 2;
            tick();
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (5) tick();
        chk("contest grant count", glog.size(), 4);
        for (int k = 0; k < 4 && k < glog.size(); k++) chk("contest grant owner", glog[k], k % 2);

        // Misaligned load answers in cycle 1 with error and no RAM traffic.
        d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 32'h22;
        tick();
        #1;
        chk("misaligned resp", {d_resp_valid, d_resp_err}, 2'b11);
        chk("misaligned data", d_resp_data, 0);
        chk("misaligned no ram", {ram_read_enable, ram_write_enable}, 0);
        tick(); tick();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            if (!if_req_valid && ($urandom % 3 == 0)) begin
                if_req_valid = 1'b1; if_req_addr = $urandom_range(0, 255);
            end
            if (!d_req_valid && ($urandom % 3 == 0)) begin
                d_req_valid = 1'b1; d_req_write = $urandom % 2; d_req_wdata = $urandom;
                d_req_addr = ($urandom % 4 == 0) ? 32'($urandom_range(0, 255))
                                                 : 32'($urandom_range(0, 63)) << 2;
            end
            tick();
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (6) tick();

        // Reset in the final ACCESS cycle of a store suppresses the write.
        mref[8] = 32'h12345678; ram[8] = 32'h12345678;
        d_req_valid = 1'b1; d_req_write = 1'b1; d_req_addr = 32'h20; d_req_wdata = 32'h55555555;
        tick(); tick();
        #1;
        chk("store strobe before reset", ram_write_enable, 1);
        reset = 1'b0;
        #1;
        chk_all_zero("mid-access reset");
        @(negedge clk); @(negedge clk);
        p_v = 1'b0; last_data = 1'b1;
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        reset = 1'b1;
        d_req_valid = 1'b1; d_req_write = 1'b0; d_req_addr = 32'h20;
        repeat (5) tick();
        chk("old value after abort", d_resp_data, 32'h12345678);
        // Reset again so the first contest after it is observable.
        reset = 1'b0; #1; reset = 1'b1;
        p_v = 1'b0; last_data = 1'b1;
        glog.delete();
        if_req_valid = 1'b1; if_req_addr = 32'h0; d_req_valid = 1'b1; d_req_addr = 32'h4;
        tick();
        chk("first grant after reset", (glog.size() == 1) ? glog[0] : -1, 0);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (8) tick();

        // Zero wait states: response in cycle 2, next fetch accepted in cycle 3.
        z_if_valid = 1'b1; z_if_addr = 32'h4;
        #1; chk("w0 ready cycle0", z_if_ready, 1);
        @(negedge clk); z_if_addr = 32'h8;
        #1; chk("w0 cycle1 read", {z_re, z_if_ready}, 2'b10);
        @(negedge clk);
        #1; chk("w0 resp cycle2", z_if_resp_valid, 1);
        chk("w0 resp data", z_if_resp_data, ramz[1]);
        @(negedge clk);
        #1; chk("w0 second ready cycle3", {z_if_ready, z_if_resp_valid}, 2'b10);
        @(negedge clk); z_if_valid = 1'b0;
        @(negedge clk);
        #1; chk("w0 second resp", {z_if_resp_valid, z_if_resp_data}, {1'b1, ramz[2]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
